video_timing_detect: RTL
========================

Name: video_timing_detect

Overview:
- Receive-side counterpart of the video timing generator: consumes raw hs/vs/hb/vb and recovers pixel/line position.
- Measures line length, active width, frame height and active height, and reports lock once timing is stable.
- Sits in front of scandoubler/OSD/capture logic that needs position and geometry from an externally timed video stream.
- One pixel per clk; no clock enable.

Parameters:
- W, 9, width of all counters and measurements; counters saturate at 2^W-1.
- LOCK_FRAMES, 2, consecutive identical frames required before locked asserts.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- hb  in  1  horizontal blank, active high
- vb  in  1  vertical blank, active high
- hcount  out  W  recovered pixel index, 0 = first active pixel
- vcount  out  W  recovered line index, 0 = first active line
- h_total  out  W  clocks per line
- h_active  out  W  clocks per line with hb low
- v_total  out  W  lines per frame
- v_active  out  W  active lines per frame
- frame  out  1  one-clock pulse per vs falling edge
- locked  out  1  timing stable
- err  out  1  one-clock pulse on timing mismatch or timeout

Behaviour:
- Reset (async, reset_n=0): all outputs 0. Internal edge registers hs_d=vs_d=1, hb_d=vb_d=1, pending=0, match count=0.
- Edge detection: inputs registered once (x_d). An edge is detected in the cycle where the current input differs from x_d. All updates take effect on that clock edge: one cycle of latency from input change to output change.
- hcount: 0 on hb falling edge; otherwise +1, saturating at 2^W-1.
- hs_cnt (internal): 1 on hs falling edge, else +1 saturating. On hs falling edge, h_total <= hs_cnt, i.e. clocks since the previous hs fall.
- h_active: hb_low_cnt counts cycles with hb low; latched into h_active and cleared on hb rising edge.
- vcount: vb falling edge sets pending. Next hb falling edge: if pending, vcount <= 0 and pending <= 0; else vcount +1, saturating. vb and hb falling in the same cycle: vb edge takes priority and sets pending; vcount resets on the following hb fall.
- v_total: line counter increments on each hs falling edge. On vs falling edge: v_total <= line count, line count <= 0, frame <= 1.
- v_active: counts hb falling edges while vb low; latched and cleared on vb rising edge.
- Lock state machine:
  - UNLOCKED: at each vs fall, compare new v_total with stored and check h_stable.
    - Equal and h_stable: match count +1.
    - Otherwise: match count <= 1.
    - Match count reaching LOCK_FRAMES: go to LOCKED, locked <= 1.
  - h_stable: set at vs fall; cleared by any hs fall whose h_total differs from the previous one.
  - LOCKED: any hs fall with changed h_total, or vs fall with changed v_total: err pulse, locked <= 0, match count <= 0, go to UNLOCKED.
  - Timeout in any state: hs_cnt saturating at 2^W-1 gives an err pulse (in LOCKED only), locked <= 0, UNLOCKED.
  - Measurements keep updating while unlocked.
- Reset mid-frame: all state cleared. The first partial line/frame after reset is measured but can never contribute a match, because the first compare always restarts the match count.

Test Plan:
- Nominal timing, line 336 clk, hb low 255 clk, hs low 24 clk, 273 lines/frame, vb low lines 16..239 -> after frame 2: h_total=336, h_active=255, v_total=273, v_active=224, locked=1. frame pulses once per 273*336 clocks. vcount=0 on the line after vb falls. hcount=0 one clock after hb sampled low.
- Locked stream, line length changed to 340 for one line -> err pulse at that line's hs fall, locked=0. Relock after 2 clean frames.
- Stop hs while locked -> err and locked=0 exactly when hs_cnt reaches 511. hcount saturates at 511.
- reset_n low mid-frame for 3 clk -> all outputs 0 immediately. locked returns only after 2 full matching frames.
- vb and hb fall in the same cycle -> vcount=0 on the next hb fall, not the current one. Frame count 273 unaffected.
- Frame height alternating 273/274 -> locked never asserts. v_total tracks each frame value.

Source files
------------

// File: rtl/video_timing_detect.sv
// video_timing_detect: recovers pixel/line position and geometry from raw hs/vs/hb/vb and reports lock
//   clk, reset_n        pixel clock, asynchronous active-low reset
//   hs, vs              syncs, active low
//   hb, vb              blanks, active high
//   hcount, vcount      recovered pixel / line index (0 = first active)
//   h_total, h_active   clocks per line, clocks per line with hb low
//   v_total, v_active   lines per frame, active lines per frame
//   frame               one-clock pulse per vs fall
//   locked, err         timing stable, one-clock pulse on mismatch/timeout while locked
module video_timing_detect #(
  parameter int W = 9,
  parameter int LOCK_FRAMES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         hs,
  input  logic         vs,
  input  logic         hb,
  input  logic         vb,
  output logic [W-1:0] hcount,
  output logic [W-1:0] vcount,
  output logic [W-1:0] h_total,
  output logic [W-1:0] h_active,
  output logic [W-1:0] v_total,
  output logic [W-1:0] v_active,
  output logic         frame,
  output logic         locked,
  output logic         err
);
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state;
  logic hs_d, vs_d, hb_d, vb_d, pending, h_stable;
  logic [W-1:0] hs_cnt, hb_low_cnt, line_cnt, act_cnt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic hs_fall, vs_fall, hb_fall, hb_rise, vb_fall, vb_rise;
  logic h_chg, v_chg, h_ok, timeout;

  function automatic logic [W-1:0] sat(input logic [W-1:0] x);
    return x == MAX ? x : x + ONE;
  endfunction

  assign hs_fall = hs_d & ~hs;
  assign vs_fall = vs_d & ~vs;
  assign hb_fall = hb_d & ~hb;
  assign hb_rise = ~hb_d & hb;
  assign vb_fall = vb_d & ~vb;
  assign vb_rise = ~vb_d & vb;
  assign h_chg = hs_fall && hs_cnt != h_total;
  assign v_chg = vs_fall && line_cnt != v_total;
  // a line ending on the vs fall itself still belongs to the frame being judged
  assign h_ok = h_stable && !h_chg;
  assign match_nxt = (h_ok && !v_chg) ? match_cnt + MW'(1) : MW'(1);
  // fires once, on the clock hs_cnt steps into saturation
  assign timeout = !hs_fall && hs_cnt == MAX - ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {hs_d, vs_d, hb_d, vb_d} <= 4'hf;
      {hcount, vcount, h_total, h_active, v_total, v_active} <= '0;
      {hs_cnt, hb_low_cnt, line_cnt, act_cnt} <= '0;
      {frame, locked, err, pending, h_stable} <= '0;
      match_cnt <= '0;
      state <= UNLOCKED;
    end else begin
      {hs_d, vs_d, hb_d, vb_d} <= {hs, vs, hb, vb};
      hcount <= hb_fall ? '0 : sat(hcount);
      hs_cnt <= hs_fall ? ONE : sat(hs_cnt);
      if (hs_fall) h_total <= hs_cnt;
      if (hb_rise) h_active <= hb_low_cnt;
      hb_low_cnt <= hb_rise ? '0 : (!hb ? sat(hb_low_cnt) : hb_low_cnt);
      // a vb fall coinciding with an hb fall arms pending; vcount resets on the next hb fall
      pending <= vb_fall ? 1'b1 : (hb_fall ? 1'b0 : pending);
      if (hb_fall) vcount <= (pending && !vb_fall) ? '0 : sat(vcount);
      // an hs fall on the vs fall opens the first line of the new frame
      line_cnt <= vs_fall ? (hs_fall ? ONE : '0) : (hs_fall ? sat(line_cnt) : line_cnt);
      if (vs_fall) v_total <= line_cnt;
      frame <= vs_fall;
      if (vb_rise) v_active <= act_cnt;
      act_cnt <= vb_rise ? '0 : ((hb_fall && !vb) ? sat(act_cnt) : act_cnt);
      h_stable <= vs_fall ? 1'b1 : (h_chg ? 1'b0 : h_stable);
      err <= 1'b0;
      if (timeout) begin
        err <= state == LOCKED;
        locked <= 1'b0;
        match_cnt <= '0;
        state <= UNLOCKED;
      end else if (state == UNLOCKED) begin
        if (vs_fall) begin
          match_cnt <= match_nxt;
          if (match_nxt >= MW'(LOCK_FRAMES)) begin
            locked <= 1'b1;
            state <= LOCKED;
          end
        end
      end else if (h_chg || v_chg) begin
        err <= 1'b1;
        locked <= 1'b0;
        match_cnt <= '0;
        state <= UNLOCKED;
      end
    end
  end
endmodule
